// File: rtl/branch_redirect_unit.sv
// branch_redirect_unit
//   Consumes the two-way predictor outputs in D, computes predicted branch
//   targets and issues fetch redirects. A slot-2 taken prediction is held
//   until its delay slot has been fetched. In E it checks predictions,
//   raises a mispredict flush with the recovery PC and keeps saturating
//   branch/mispredict counters.
//
// Ports
//   clk, rst (async, active-low)
//   D side : stall_masterD, flush_masterD, PcD, instr1D, instr2D,
//            branch1D/2D, pred_take1D/2D, ds_fetchedF
//   E side : branch1E/2E, pred_take1E/2E, actual_take1E/2E, PcE,
//            target1E, target2E
//   Outputs: pred_redirect/pred_target (1-cycle pulse), mispredE/recover_pc
//            (1-cycle pulse), branch_cnt, mispred_cnt, state_dbg (1 = WAIT_DS)
//
// Handshake: pred_redirect and mispredE are single-cycle strobes with no
// back-pressure; their data (pred_target, recover_pc) is valid in the same
// cycle as the strobe. D inputs are taken only when the D stage is neither
// stalled nor flushed and no slot-2 redirect is already being held.
module branch_redirect_unit #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_masterD,
  input  logic             flush_masterD,
  input  logic [31:0]      PcD,
  input  logic [31:0]      instr1D,
  input  logic [31:0]      instr2D,
  input  logic             branch1D,
  input  logic             branch2D,
  input  logic             pred_take1D,
  input  logic             pred_take2D,
  input  logic             ds_fetchedF,
  input  logic             branch1E,
  input  logic             branch2E,
  input  logic             pred_take1E,
  input  logic             pred_take2E,
  input  logic             actual_take1E,
  input  logic             actual_take2E,
  input  logic [31:0]      PcE,
  input  logic [31:0]      target1E,
  input  logic [31:0]      target2E,
  output logic             pred_redirect,
  output logic [31:0]      pred_target,
  output logic             mispredE,
  output logic [31:0]      recover_pc,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt,
  output logic             state_dbg
);

  typedef enum logic {
    IDLE    = 1'b0,
    WAIT_DS = 1'b1
  } state_t;

  state_t      state;
  logic [31:0] held_target;

  logic        accept_d;
  logic [31:0] tgt1;
  logic [31:0] tgt2;
  logic        mis1;
  logic        mis2;
  logic        mis_any;
  logic [31:0] rec_pc;
  logic [CNT_W:0] bsum;

  assign state_dbg = (state == WAIT_DS);

  assign accept_d = ~stall_masterD & ~flush_masterD & (state == IDLE);

  // Branch offset is imm16 sign-extended and scaled to words, relative to
  // the address of the delay slot (branch PC + 4). Wrap-around is natural.
  assign tgt1 = PcD + 32'd4 + {{14{instr1D[15]}}, instr1D[15:0], 2'b00};
  assign tgt2 = PcD + 32'd8 + {{14{instr2D[15]}}, instr2D[15:0], 2'b00};

  // Slot 1 is older, so its mispredict masks slot 2.
  assign mis1    = branch1E & (pred_take1E ^ actual_take1E);
  assign mis2    = branch2E & (pred_take2E ^ actual_take2E) & ~mis1;
  assign mis_any = mis1 | mis2;

  // Not-taken recovery skips the branch and its delay slot.
  always_comb begin
    rec_pc = 32'd0;
    if (mis1) rec_pc = actual_take1E ? target1E : (PcE + 32'd8);
    else if (mis2) rec_pc = actual_take2E ? target2E : (PcE + 32'd12);
  end

  // One extra bit catches overflow for the saturating add of 0..2.
  assign bsum = {1'b0, branch_cnt} + (CNT_W+1)'(branch1E) + (CNT_W+1)'(branch2E);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      held_target   <= 32'd0;
      pred_redirect <= 1'b0;
      pred_target   <= 32'd0;
      mispredE      <= 1'b0;
      recover_pc    <= 32'd0;
      branch_cnt    <= '0;
      mispred_cnt   <= '0;
    end else begin
      pred_redirect <= 1'b0;
      mispredE      <= mis_any;

      if (mis_any) begin
        // The D group is younger than the mispredicted branch: drop any
        // pending slot-2 redirect and any redirect that would issue now.
        recover_pc <= rec_pc;
        state      <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (accept_d) begin
              if (branch1D && pred_take1D) begin
                // Slot 2 is the delay slot and already fetched.
                pred_redirect <= 1'b1;
                pred_target   <= tgt1;
              end else if (branch2D && pred_take2D) begin
                held_target <= tgt2;
                if (ds_fetchedF) begin
                  pred_redirect <= 1'b1;
                  pred_target   <= tgt2;
                end else begin
                  state <= WAIT_DS;
                end
              end
            end
          end
          WAIT_DS: begin
            if (ds_fetchedF) begin
              state         <= IDLE;
              pred_redirect <= 1'b1;
              pred_target   <= held_target;
            end
          end
          default: state <= IDLE;
        endcase
      end

      if (bsum[CNT_W]) branch_cnt <= '1;
      else             branch_cnt <= bsum[CNT_W-1:0];

      if (mis_any && (mispred_cnt != '1)) mispred_cnt <= mispred_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_redirect_unit.sv
module tb_branch_redirect_unit;

  logic        clk;
  logic        rst;
  logic        stall_masterD, flush_masterD;
  logic [31:0] PcD, instr1D, instr2D;
  logic        branch1D, branch2D, pred_take1D, pred_take2D, ds_fetchedF;
  logic        branch1E, branch2E, pred_take1E, pred_take2E;
  logic        actual_take1E, actual_take2E;
  logic [31:0] PcE, target1E, target2E;

  logic        pred_redirect, mispredE, state_dbg;
  logic [31:0] pred_target, recover_pc;
  logic [31:0] branch_cnt, mispred_cnt;

  logic        s_pred_redirect, s_mispredE, s_state_dbg;
  logic [31:0] s_pred_target, s_recover_pc;
  logic [3:0]  s_branch_cnt, s_mispred_cnt;

  int pass_cnt;
  int total_cnt;

  branch_redirect_unit #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .stall_masterD(stall_masterD), .flush_masterD(flush_masterD),
    .PcD(PcD), .instr1D(instr1D), .instr2D(instr2D),
    .branch1D(branch1D), .branch2D(branch2D),
    .pred_take1D(pred_take1D), .pred_take2D(pred_take2D),
    .ds_fetchedF(ds_fetchedF),
    .branch1E(branch1E), .branch2E(branch2E),
    .pred_take1E(pred_take1E), .pred_take2E(pred_take2E),
    .actual_take1E(actual_take1E), .actual_take2E(actual_take2E),
    .PcE(PcE), .target1E(target1E), .target2E(target2E),
    .pred_redirect(pred_redirect), .pred_target(pred_target),
    .mispredE(mispredE), .recover_pc(recover_pc),
    .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt),
    .state_dbg(state_dbg)
  );

  // Narrow-counter instance sharing the same stimulus, for saturation.
  branch_redirect_unit #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst),
    .stall_masterD(stall_masterD), .flush_masterD(flush_masterD),
    .PcD(PcD), .instr1D(instr1D), .instr2D(instr2D),
    .branch1D(branch1D), .branch2D(branch2D),
    .pred_take1D(pred_take1D), .pred_take2D(pred_take2D),
    .ds_fetchedF(ds_fetchedF),
    .branch1E(branch1E), .branch2E(branch2E),
    .pred_take1E(pred_take1E), .pred_take2E(pred_take2E),
    .actual_take1E(actual_take1E), .actual_take2E(actual_take2E),
    .PcE(PcE), .target1E(target1E), .target2E(target2E),
    .pred_redirect(s_pred_redirect), .pred_target(s_pred_target),
    .mispredE(s_mispredE), .recover_pc(s_recover_pc),
    .branch_cnt(s_branch_cnt), .mispred_cnt(s_mispred_cnt),
    .state_dbg(s_state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall_masterD = 0; flush_masterD = 0;
    PcD = 0; instr1D = 0; instr2D = 0;
    branch1D = 0; branch2D = 0; pred_take1D = 0; pred_take2D = 0;
    branch1E = 0; branch2E = 0; pred_take1E = 0; pred_take2E = 0;
    actual_take1E = 0; actual_take2E = 0;
    PcE = 0; target1E = 0; target2E = 0;
  endtask

  task automatic drive_slot1(input logic [31:0] pc, input logic [15:0] imm);
    PcD = pc; instr1D = {16'h1000, imm}; branch1D = 1; pred_take1D = 1;
  endtask

  task automatic drive_slot2(input logic [31:0] pc, input logic [15:0] imm);
    PcD = pc; instr2D = {16'h1400, imm}; branch2D = 1; pred_take2D = 1;
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    clear_inputs();
    ds_fetchedF = 0;
    rst = 0;
    #1;
    check("reset_redirect", {31'd0, pred_redirect}, 32'd0);
    check("reset_target", pred_target, 32'd0);
    check("reset_mispred", {31'd0, mispredE}, 32'd0);
    check("reset_recover", recover_pc, 32'd0);
    check("reset_bcnt", branch_cnt, 32'd0);
    check("reset_state", {31'd0, state_dbg}, 32'd0);
    step(); step();
    rst = 1;
    step();

    // Slot-1 taken: 0x1000 + 4 + 4*4 = 0x1014
    drive_slot1(32'h1000, 16'h0004);
    step();
    clear_inputs();
    check("s1_redirect", {31'd0, pred_redirect}, 32'd1);
    check("s1_target", pred_target, 32'h1014);
    step();
    check("s1_pulse_end", {31'd0, pred_redirect}, 32'd0);

    // Slot-2 held: 0x2004 + 4 - 4 = 0x2004
    drive_slot2(32'h2000, 16'hFFFF);
    ds_fetchedF = 0;
    step();
    clear_inputs();
    check("s2_wait_state", {31'd0, state_dbg}, 32'd1);
    check("s2_wait_redir0", {31'd0, pred_redirect}, 32'd0);
    step();
    check("s2_wait_redir1", {31'd0, pred_redirect}, 32'd0);
    step();
    check("s2_wait_redir2", {31'd0, pred_redirect}, 32'd0);
    ds_fetchedF = 1;
    step();
    ds_fetchedF = 0;
    check("s2_redirect", {31'd0, pred_redirect}, 32'd1);
    check("s2_target", pred_target, 32'h2004);
    check("s2_idle", {31'd0, state_dbg}, 32'd0);
    step();
    check("s2_pulse_end", {31'd0, pred_redirect}, 32'd0);

    // Slot-2 with delay slot already fetched: 0x7008 + 0x40 = 0x7048
    drive_slot2(32'h7000, 16'h0010);
    ds_fetchedF = 1;
    step();
    clear_inputs();
    ds_fetchedF = 0;
    check("s2imm_redirect", {31'd0, pred_redirect}, 32'd1);
    check("s2imm_target", pred_target, 32'h7048);
    check("s2imm_state", {31'd0, state_dbg}, 32'd0);

    // Slot-1 taken wins over slot-2 taken
    drive_slot1(32'h8000, 16'h0002);
    instr2D = 32'h0000_0100; branch2D = 1; pred_take2D = 1;
    step();
    clear_inputs();
    check("prio_target", pred_target, 32'h800C);
    check("prio_state", {31'd0, state_dbg}, 32'd0);

    // Stall and flush block D acceptance
    drive_slot1(32'h1000, 16'h0004);
    stall_masterD = 1;
    step();
    check("stall_redir", {31'd0, pred_redirect}, 32'd0);
    stall_masterD = 0; flush_masterD = 1;
    step();
    clear_inputs();
    check("flush_redir", {31'd0, pred_redirect}, 32'd0);

    // Target wrap: 0xFFFFFFF4 + 0x40 = 0x34
    drive_slot1(32'hFFFF_FFF0, 16'h0010);
    step();
    clear_inputs();
    check("wrap_target", pred_target, 32'h0000_0034);

    // Slot-1 mispredict, actually not taken
    PcE = 32'h3000; branch1E = 1; pred_take1E = 1; actual_take1E = 0;
    step();
    clear_inputs();
    check("mis1_flag", {31'd0, mispredE}, 32'd1);
    check("mis1_recover", recover_pc, 32'h3008);
    check("mis1_mcnt", mispred_cnt, 32'd1);
    check("mis1_bcnt", branch_cnt, 32'd1);
    step();
    check("mis1_pulse_end", {31'd0, mispredE}, 32'd0);

    // Both slots mispredict while WAIT_DS pending and delay slot arriving
    drive_slot2(32'h5000, 16'h0008);
    ds_fetchedF = 0;
    step();
    clear_inputs();
    check("both_pre_wait", {31'd0, state_dbg}, 32'd1);
    PcE = 32'h4000;
    branch1E = 1; pred_take1E = 0; actual_take1E = 1; target1E = 32'h4400;
    branch2E = 1; pred_take2E = 1; actual_take2E = 0; target2E = 32'h4800;
    ds_fetchedF = 1;
    step();
    clear_inputs();
    ds_fetchedF = 0;
    check("both_flag", {31'd0, mispredE}, 32'd1);
    check("both_recover", recover_pc, 32'h4400);
    check("both_mcnt", mispred_cnt, 32'd2);
    check("both_bcnt", branch_cnt, 32'd3);
    check("both_state", {31'd0, state_dbg}, 32'd0);
    check("both_no_redir", {31'd0, pred_redirect}, 32'd0);
    step();
    check("both_no_redir_late", {31'd0, pred_redirect}, 32'd0);

    // Slot-2 mispredict, actually not taken: PcE + 12
    PcE = 32'h6000; branch2E = 1; pred_take2E = 1; actual_take2E = 0;
    step();
    clear_inputs();
    check("mis2_recover", recover_pc, 32'h600C);
    check("mis2_mcnt", mispred_cnt, 32'd3);

    // Correct predictions: 20 branches, no mispredicts
    for (int i = 0; i < 10; i++) begin
      branch1E = 1; branch2E = 1;
      pred_take1E = 1; actual_take1E = 1;
      pred_take2E = 0; actual_take2E = 0;
      step();
    end
    clear_inputs();
    check("cnt_bcnt", branch_cnt, 32'd24);
    check("cnt_mcnt", mispred_cnt, 32'd3);
    check("cnt_no_mis", {31'd0, mispredE}, 32'd0);
    check("sat_bcnt", {28'd0, s_branch_cnt}, 32'h0000_000F);
    check("sat_mcnt", {28'd0, s_mispred_cnt}, 32'd3);
    branch1E = 1; branch2E = 1;
    step();
    clear_inputs();
    check("sat_hold", {28'd0, s_branch_cnt}, 32'h0000_000F);

    // Mid-operation reset in WAIT_DS
    drive_slot2(32'h9000, 16'h0004);
    ds_fetchedF = 0;
    step();
    clear_inputs();
    check("rst_pre_wait", {31'd0, state_dbg}, 32'd1);
    #2;
    rst = 0;
    #1;
    check("rst_mid_state", {31'd0, state_dbg}, 32'd0);
    check("rst_mid_redir", {31'd0, pred_redirect}, 32'd0);
    check("rst_mid_target", pred_target, 32'd0);
    check("rst_mid_bcnt", branch_cnt, 32'd0);
    check("rst_mid_mcnt", mispred_cnt, 32'd0);
    ds_fetchedF = 1;
    step();
    rst = 1;
    step();
    check("rst_after_redir0", {31'd0, pred_redirect}, 32'd0);
    step();
    check("rst_after_redir1", {31'd0, pred_redirect}, 32'd0);
    ds_fetchedF = 0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
